alu_result_buffer: RTL and testbench

- Two-entry elastic skid buffer directly downstream of the combinational 32-bit ALU, at the execute/writeback boundary.
- Captures the ALU outputs with a valid/ready handshake and selects the architectural result (Y, or the SLT word Less).
- Sanitises don't-care ALU outputs, converts signed overflow into an exception flag with write suppression, and counts overflow events.
- Isolates the writeback consumer's back-pressure from the ALU's combinational path.

---
 rtl/alu_result_buffer_if.sv | 46 ++++
 rtl/alu_result_buffer.sv | 145 ++++++++++++++
 tb/tb_alu_result_buffer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_buffer_if
//  Description : Handshake/bus bundle between the ALU stage, the result
//                buffer and the writeback consumer.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_result_buffer_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      alu_y;
    logic [31:0]      alu_less;
    logic             alu_overflow;
    logic             alu_zero;
    logic             sel_less;
    logic             ovf_chk;
    logic [4:0]       rd;
    logic             wen;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      wb_data;
    logic [4:0]       wb_rd;
    logic             wb_wen;
    logic             wb_zero;
    logic             wb_exc;
    logic [CNT_W-1:0] ovf_count;

    // Upstream/consumer side: drives ALU fields and out_ready
    modport master (
        output in_valid, alu_y, alu_less, alu_overflow, alu_zero, sel_less,
               ovf_chk, rd, wen, flush, out_ready,
        input  in_ready, out_valid, wb_data, wb_rd, wb_wen, wb_zero, wb_exc,
               ovf_count
    );

    modport slave (
        input  in_valid, alu_y, alu_less, alu_overflow, alu_zero, sel_less,
               ovf_chk, rd, wen, flush, out_ready,
        output in_ready, out_valid, wb_data, wb_rd, wb_wen, wb_zero, wb_exc,
               ovf_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_buffer
//  Description : Two-entry skid buffer at the execute/writeback boundary;
//                selects the ALU result, flags overflow, counts exceptions.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_result_buffer #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    alu_result_buffer_if.slave  bus
);

    generate
        if (DEPTH != 2) begin : g_depth_check
            $error("alu_result_buffer: only DEPTH=2 is supported");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic        zero;
        logic        exc;
    } entry_t;

    state_t           r_state;
    state_t           w_state_nxt;
    entry_t           r_head;
    entry_t           r_skid;
    entry_t           w_new;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_ovf_cnt;
    logic             w_acc;
    logic             w_drn;
    logic             w_exc;
    logic             w_load_head_new;
    logic             w_load_head_skid;
    logic             w_load_skid;

    assign w_acc = bus.in_valid & r_in_ready;
    assign w_drn = (r_state != S_EMPTY) & bus.out_ready;

    // Case equality keeps an X/Z overflow from propagating into the flag
    always_comb begin
        w_exc      = bus.ovf_chk & (bus.alu_overflow === 1'b1);
        w_new.data = bus.sel_less ? bus.alu_less : bus.alu_y;
        w_new.rd   = bus.rd;
        w_new.exc  = w_exc;
        w_new.wen  = bus.wen & ~w_exc & (bus.rd != 5'd0);
        w_new.zero = bus.alu_zero;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_head_new  = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (bus.flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt     = S_ONE;
                        w_load_head_new = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_acc && w_drn) begin
                        w_load_head_new = 1'b1;
                    end else if (w_acc) begin
                        w_state_nxt = S_TWO;
                        w_load_skid = 1'b1;
                    end else if (w_drn) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_drn) begin
                        w_state_nxt      = S_ONE;
                        w_load_head_skid = 1'b1;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != S_TWO);
        end
    end

    // Head only moves on a drain or on a fill from empty, so it stays stable under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_head_new) begin
                r_head <= w_new;
            end else if (w_load_head_skid) begin
                r_head <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_new;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_cnt <= '0;
        end else if (w_acc && w_exc && !bus.flush && !(&r_ovf_cnt)) begin
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_state != S_EMPTY);
    assign bus.wb_data   = r_head.data;
    assign bus.wb_rd     = r_head.rd;
    assign bus.wb_wen    = r_head.wen;
    assign bus.wb_zero   = r_head.zero;
    assign bus.wb_exc    = r_head.exc;
    assign bus.ovf_count = r_ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_result_buffer
//  Description : Scoreboard bench for alu_result_buffer (random + directed).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_result_buffer;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    alu_result_buffer_if #(.CNT_W(CNT_W)) bus ();

    alu_result_buffer #(.DEPTH(2), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic        zero;
        logic        exc;
    } exp_t;

    exp_t q[$];
    int   model_cnt = 0;
    int   n_pass    = 0;
    int   n_total   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        else n_pass++;
    endtask

    // One upstream cycle: drive after the falling edge, decide acceptance just before the rising edge
    task automatic drive(input logic v, input logic [31:0] y, input logic [31:0] less,
                         input logic ovf, input logic z, input logic sl, input logic oc,
                         input logic [4:0] rd, input logic wen, input logic fl,
                         input logic ordy, output logic acc);
        exp_t e;
        @(negedge clk);
        bus.in_valid     = v;
        bus.alu_y        = y;
        bus.alu_less     = less;
        bus.alu_overflow = ovf;
        bus.alu_zero     = z;
        bus.sel_less     = sl;
        bus.ovf_chk      = oc;
        bus.rd           = rd;
        bus.wen          = wen;
        bus.flush        = fl;
        bus.out_ready    = ordy;
        #3;
        acc = v && (bus.in_ready === 1'b1);
        if (fl) begin
            q.delete();
        end else if (acc) begin
            e.data = sl ? less : y;
            e.exc  = oc && (ovf === 1'b1);
            e.wen  = wen && !e.exc && (rd != 5'd0);
            e.rd   = rd;
            e.zero = z;
            q.push_back(e);
            if (e.exc && model_cnt < CNT_MAX) model_cnt++;
        end
    endtask

    task automatic idle(input logic ordy);
        logic a;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, ordy, a);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        q.delete();
        model_cnt    = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: occupancy-derived handshake checks and in-order scoreboard pop
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                chk("ovf_count", 32'(bus.ovf_count), 32'(model_cnt));
                chk("in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() < 2});
                chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
                if (bus.out_valid && bus.out_ready && !bus.flush && q.size() != 0) begin
                    e = q.pop_front();
                    chk("wb_data", bus.wb_data, e.data);
                    chk("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
                    chk("wb_wen", {31'd0, bus.wb_wen}, {31'd0, e.wen});
                    chk("wb_zero", {31'd0, bus.wb_zero}, {31'd0, e.zero});
                    chk("wb_exc", {31'd0, bus.wb_exc}, {31'd0, e.exc});
                end
            end
        end
    end

    initial begin
        logic        acc;
        logic        v, ordy, fl, oc, ovf, z, sl, wen;
        logic [4:0]  rd;
        logic [31:0] y, less;
        int          pre;
        int          n;

        rst_n            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.alu_y        = '0;
        bus.alu_less     = '0;
        bus.alu_overflow = 1'b0;
        bus.alu_zero     = 1'b0;
        bus.sel_less     = 1'b0;
        bus.ovf_chk      = 1'b0;
        bus.rd           = '0;
        bus.wen          = 1'b0;
        bus.flush        = 1'b0;
        bus.out_ready    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_wb_flags", {27'd0, bus.wb_rd}, 32'd0);
        chk("rst_wb_bits", {29'd0, bus.wb_wen, bus.wb_zero, bus.wb_exc}, 32'd0);
        chk("rst_ovf_count", 32'(bus.ovf_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single accept, one-cycle latency
        drive(1'b1, 32'h0000_00FF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, acc);
        idle(1'b1);
        chk("single_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("single_data", bus.wb_data, 32'h0000_00FF);
        chk("single_wen", {31'd0, bus.wb_wen}, 32'd1);
        idle(1'b1);
        chk("single_gone", {31'd0, bus.out_valid}, 32'd0);

        // SLT path with unknown Y
        drive(1'b1, 32'hxxxx_xxxx, 32'h1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, acc);
        idle(1'b1);
        chk("slt_data", bus.wb_data, 32'h1);
        chk("slt_nox", {31'd0, $isunknown({bus.wb_data, bus.wb_rd, bus.wb_wen, bus.wb_zero, bus.wb_exc})}, 32'd0);

        // Overflow trap, then the same word with checking disabled and X overflow
        drive(1'b1, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, acc);
        idle(1'b1);
        chk("ovf_exc", {31'd0, bus.wb_exc}, 32'd1);
        chk("ovf_wen", {31'd0, bus.wb_wen}, 32'd0);
        chk("ovf_cnt1", 32'(bus.ovf_count), 32'd1);
        drive(1'b1, 32'h8000_0000, 32'h0, 1'bx, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, acc);
        idle(1'b1);
        chk("noovf_exc", {31'd0, bus.wb_exc}, 32'd0);
        chk("noovf_wen", {31'd0, bus.wb_wen}, 32'd1);
        chk("noovf_cnt", 32'(bus.ovf_count), 32'd1);

        // Back-pressure: A, B captured, C held upstream until the skid drains
        drive(1'b1, 32'h111, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, acc);
        drive(1'b1, 32'h222, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, acc);
        drive(1'b1, 32'h333, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, acc);
        chk("bp_c_held", {31'd0, acc}, 32'd0);
        chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        n = 0;
        do begin
            drive(1'b1, 32'h333, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, acc);
            n++;
        end while (!acc && n < 6);
        chk("bp_c_accept", {31'd0, acc}, 32'd1);
        repeat (3) idle(1'b1);

        // Flush while full with an overflow entry offered
        pre = model_cnt;
        drive(1'b1, 32'h444, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, acc);
        drive(1'b1, 32'h555, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, acc);
        drive(1'b1, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, acc);
        idle(1'b0);
        chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("flush_cnt", 32'(bus.ovf_count), 32'(pre));

        // Randomised traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 31) == 0);
            oc   = ($urandom_range(0, 1) == 1);
            ovf  = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0) ovf = 1'bx;
            z    = ($urandom_range(0, 1) == 1);
            sl   = ($urandom_range(0, 3) == 0);
            wen  = ($urandom_range(0, 3) != 0);
            rd   = 5'($urandom_range(0, 31));
            y    = $urandom();
            less = {31'd0, ($urandom_range(0, 1) == 1)};
            drive(v, y, less, ovf, z, sl, oc, rd, wen, fl, ordy, acc);
        end
        repeat (4) idle(1'b1);

        // Counter saturation from a clean reset
        reset_dut();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 32'(i), 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, acc);
        end
        idle(1'b1);
        chk("sat_cnt", 32'(bus.ovf_count), 32'hF);

        // Asynchronous reset in the middle of a stream
        drive(1'b1, 32'hAAAA, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, acc);
        drive(1'b1, 32'hBBBB, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, acc);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        model_cnt = 0;
        #1;
        chk("arst_cnt", 32'(bus.ovf_count), 32'd0);
        chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle(1'b1);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
